// File: rtl/cpu_program_loader_if.sv
// -----------------------------------------------------------------------------
// cpu_program_loader_if
//
// 32-bit valid/ready word stream that carries a framed program image into
// cpu_program_loader.
//
// Signals:
//   in_valid  producer -> loader  word on in_data is valid
//   in_ready  loader -> producer  loader can accept a word this cycle
//   in_data   producer -> loader  stream word
// A beat transfers when in_valid and in_ready are both high on a rising edge.
//
// Modports:
//   master  the producer side (drives in_valid / in_data)
//   slave   the loader side (drives in_ready)
// -----------------------------------------------------------------------------
interface cpu_program_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/cpu_program_loader.sv
// -----------------------------------------------------------------------------
// cpu_program_loader
//
// Boot-time loader placed in front of the cpu top. It consumes a framed
// program image from a valid/ready word stream, writes instruction memory
// (*_ext ports, 32-bit words) and data memory (*_ext_2 ports, 64-bit dwords),
// then raises cpu_enable and holds it until the next load starts.
//
// Frame: header {n_data[15:0], n_instr[15:0]}, n_instr instruction words,
//        2*n_data data beats (low half first), and a trailing checksum word
//        when LOADER_CHECKSUM_EN is defined.
//
// Compile-time option:
//   LOADER_CHECKSUM_EN  adds a CHECK state; the trailing word must equal the
//                       XOR of the header and all payload beats, otherwise the
//                       load ends in ERROR.
//
// Ports:
//   clk, arst_n            clock, asynchronous active-low reset
//   start                  one-cycle pulse starting a load (ignored while busy)
//   in_s                   stream input (slave modport)
//   addr_ext/wen_ext/...   instruction-memory write port, ren_ext tied 0
//   addr_ext_2/wen_ext_2/..data-memory write port, ren_ext_2 tied 0
//   cpu_enable             CPU enable, high only once the image is complete
//   busy, done, error      status: loading / loaded OK / load rejected
// -----------------------------------------------------------------------------
module cpu_program_loader #(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       start,
    cpu_program_loader_if.slave        in_s,
    output logic [63:0]                addr_ext,
    output logic                       wen_ext,
    output logic                       ren_ext,
    output logic [31:0]                wdata_ext,
    output logic [63:0]                addr_ext_2,
    output logic                       wen_ext_2,
    output logic                       ren_ext_2,
    output logic [63:0]                wdata_ext_2,
    output logic                       cpu_enable,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_INSTR,
        ST_DATA_LO,
        ST_DATA_HI,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_RUN,
        ST_ERROR
    } state_e;

    // State entered once the last payload beat has been consumed.
`ifdef LOADER_CHECKSUM_EN
    localparam state_e END_STATE = ST_CHECK;
`else
    localparam state_e END_STATE = ST_RUN;
`endif

    state_e      state_q, state_d;
    logic [15:0] n_instr_q, n_instr_d;
    logic [15:0] n_data_q, n_data_d;
    logic [15:0] icnt_q, icnt_d;
    logic [15:0] dcnt_q, dcnt_d;
    logic [31:0] lo_q, lo_d;
    logic        imem_wen_q, imem_wen_d;
    logic [63:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic [63:0] dmem_addr_q, dmem_addr_d;
    logic [63:0] dmem_wdata_q, dmem_wdata_d;
    logic        cpu_enable_q, cpu_enable_d;
    // Low for the first edge after reset release so a start pulse that
    // coincides with the release is ignored.
    logic        armed_q;
    logic        accept;

    assign busy           = (state_q != ST_IDLE) && (state_q != ST_RUN) && (state_q != ST_ERROR);
    assign in_s.in_ready  = busy;
    assign accept         = in_s.in_valid && busy;
    assign done           = (state_q == ST_RUN);
    assign error          = (state_q == ST_ERROR);
    assign cpu_enable     = cpu_enable_q;
    assign ren_ext        = 1'b0;
    assign ren_ext_2      = 1'b0;
    assign wen_ext        = imem_wen_q;
    assign addr_ext       = imem_addr_q;
    assign wdata_ext      = imem_wdata_q;
    assign wen_ext_2      = dmem_wen_q;
    assign addr_ext_2     = dmem_addr_q;
    assign wdata_ext_2    = dmem_wdata_q;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    // Running XOR restarts at the header; the checksum beat itself also folds
    // in, but only after CHECK has already compared against csum_q.
    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            csum_d = (state_q == ST_HEADER) ? in_s.in_data : (csum_q ^ in_s.in_data);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) csum_q <= '0;
        else         csum_q <= csum_d;
    end
`endif

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        n_instr_d    = n_instr_q;
        n_data_d     = n_data_q;
        icnt_d       = icnt_q;
        dcnt_d       = dcnt_q;
        lo_d         = lo_q;
        imem_wen_d   = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        dmem_wen_d   = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start && armed_q) begin
                    state_d = ST_HEADER;
                    icnt_d  = '0;
                    dcnt_d  = '0;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    n_instr_d = in_s.in_data[15:0];
                    n_data_d  = in_s.in_data[31:16];
                    if (({16'd0, in_s.in_data[15:0]} > IMEM_WORDS) ||
                        ({16'd0, in_s.in_data[31:16]} > DMEM_WORDS)) begin
                        state_d = ST_ERROR;
                    end else if (in_s.in_data[15:0] != '0) begin
                        state_d = ST_INSTR;
                    end else if (in_s.in_data[31:16] != '0) begin
                        state_d = ST_DATA_LO;
                    end else begin
                        state_d = END_STATE;
                    end
                end
            end
            ST_INSTR: begin
                if (accept) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = {46'd0, icnt_q, 2'b00};
                    imem_wdata_d = in_s.in_data;
                    icnt_d       = icnt_q + 16'd1;
                    if ((icnt_q + 16'd1) == n_instr_q) begin
                        state_d = (n_data_q != '0) ? ST_DATA_LO : END_STATE;
                    end
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    lo_d    = in_s.in_data;
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    dmem_wen_d   = 1'b1;
                    dmem_addr_d  = {45'd0, dcnt_q, 3'b000};
                    dmem_wdata_d = {in_s.in_data, lo_q};
                    dcnt_d       = dcnt_q + 16'd1;
                    state_d      = ((dcnt_q + 16'd1) == n_data_q) ? END_STATE : ST_DATA_LO;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) begin
                    state_d = (in_s.in_data == csum_q) ? ST_RUN : ST_ERROR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Enable only after a full cycle in RUN, so it trails the last write
        // strobe by one cycle and drops as soon as a restart leaves RUN.
        cpu_enable_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            n_instr_q    <= '0;
            n_data_q     <= '0;
            icnt_q       <= '0;
            dcnt_q       <= '0;
            lo_q         <= '0;
            imem_wen_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            dmem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            cpu_enable_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_instr_q    <= n_instr_d;
            n_data_q     <= n_data_d;
            icnt_q       <= icnt_d;
            dcnt_q       <= dcnt_d;
            lo_q         <= lo_d;
            imem_wen_q   <= imem_wen_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            cpu_enable_q <= cpu_enable_d;
            armed_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// -----------------------------------------------------------------------------
// tb_cpu_program_loader
//
// Directed bench for cpu_program_loader. A beat-index model of the frame
// format predicts status flags, write strobes, addresses and data every cycle;
// directed tests additionally pin captured writes to hand-computed literals.
// Builds with or without LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic [31:0] wdata_ext;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, done, error;

    cpu_program_loader_if in_if ();

    cpu_program_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .start       (start),
        .in_s        (in_if),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- frame model (beat index -> meaning) ----------------
    bit          m_loading = 0;
    bit          m_armed   = 0;
    int          m_idx     = 0;
    int          m_ni      = 0;
    int          m_nd      = 0;
    int          m_status  = 0;  // 0 idle/loading, 1 run, 2 error
    logic [31:0] m_xor     = '0;
    logic [31:0] m_lo      = '0;
    bit          m_en      = 0;
    bit          m_wen     = 0;
    bit          m_wen2    = 0;
    logic [63:0] m_addr    = '0;
    logic [31:0] m_wdata   = '0;
    logic [63:0] m_addr2   = '0;
    logic [63:0] m_wdata2  = '0;

    // Captured writes, cleared by the stimulus at the start of a test.
    logic [63:0] cap_ia[$];
    logic [31:0] cap_id[$];
    logic [63:0] cap_da[$];
    logic [63:0] cap_dd[$];

    // Advance the model across the coming rising edge using the inputs that
    // are stable now.
    function automatic void model_step();
        bit          prev_run = (m_status == 1);
        logic [31:0] d        = in_if.in_data;
        m_wen  = 0;
        m_wen2 = 0;
        if (!m_loading) begin
            if (start && m_armed) begin
                m_loading = 1;
                m_idx     = 0;
                m_status  = 0;
                m_xor     = '0;
            end
        end else if (in_if.in_valid) begin
            if (m_idx == 0) begin
                m_ni  = int'(d[15:0]);
                m_nd  = int'(d[31:16]);
                m_xor = d;
                if (m_ni > 512 || m_nd > 1024) begin
                    m_loading = 0;
                    m_status  = 2;
                end
            end else if (m_idx <= m_ni) begin
                m_wen   = 1;
                m_addr  = 64'(4 * (m_idx - 1));
                m_wdata = d;
                m_xor   = m_xor ^ d;
            end else if (m_idx <= m_ni + 2 * m_nd) begin
                int j = m_idx - m_ni - 1;
                m_xor = m_xor ^ d;
                if (j % 2 == 0) begin
                    m_lo = d;
                end else begin
                    m_wen2   = 1;
                    m_addr2  = 64'(8 * (j / 2));
                    m_wdata2 = {d, m_lo};
                end
            end else begin
                m_loading = 0;
                m_status  = (d == m_xor) ? 1 : 2;
            end
            m_idx++;
`ifndef LOADER_CHECKSUM_EN
            if (m_loading && m_idx == m_ni + 2 * m_nd + 1) begin
                m_loading = 0;
                m_status  = 1;
            end
`endif
        end
        m_en    = prev_run && (m_status == 1);
        m_armed = 1;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!arst_n) begin
            check("rst_wen",        wen_ext,         1'b0);
            check("rst_wen2",       wen_ext_2,       1'b0);
            check("rst_addr",       addr_ext,        64'd0);
            check("rst_addr2",      addr_ext_2,      64'd0);
            check("rst_wdata",      wdata_ext,       32'd0);
            check("rst_wdata2",     wdata_ext_2,     64'd0);
            check("rst_status",     {cpu_enable, busy, done, error, in_if.in_ready}, 5'd0);
            m_loading = 0;
            m_armed   = 0;
            m_status  = 0;
            m_idx     = 0;
            m_en      = 0;
            m_wen     = 0;
            m_wen2    = 0;
        end else begin
            check("ren_ext",    ren_ext,        1'b0);
            check("ren_ext_2",  ren_ext_2,      1'b0);
            check("in_ready",   in_if.in_ready, m_loading);
            check("busy",       busy,           m_loading);
            check("done",       done,           m_status == 1);
            check("error",      error,          m_status == 2);
            check("cpu_enable", cpu_enable,     m_en);
            check("wen_ext",    wen_ext,        m_wen);
            check("wen_ext_2",  wen_ext_2,      m_wen2);
            if (m_wen) begin
                check("addr_ext",  addr_ext,  m_addr);
                check("wdata_ext", wdata_ext, m_wdata);
            end
            if (m_wen2) begin
                check("addr_ext_2",  addr_ext_2,  m_addr2);
                check("wdata_ext_2", wdata_ext_2, m_wdata2);
            end
            if (wen_ext) begin
                cap_ia.push_back(addr_ext);
                cap_id.push_back(wdata_ext);
            end
            if (wen_ext_2) begin
                cap_da.push_back(addr_ext_2);
                cap_dd.push_back(wdata_ext_2);
            end
            model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] tb_xor;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic start_load();
        tb_xor = '0;
        cap_ia.delete();
        cap_id.delete();
        cap_da.delete();
        cap_dd.delete();
        pulse_start();
    endtask

    // Present one word and hold it until accepted (bounded); returns 1 ns
    // after the accepting edge.
    task automatic send(input logic [31:0] w, input bit gaps);
        bit rdy   = 0;
        int guard = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                in_if.in_valid = 1'b0;
                tick();
            end
        end
        in_if.in_valid = 1'b1;
        in_if.in_data  = w;
        do begin
            @(negedge clk);
            rdy = in_if.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 20);
        check("send_accepted", rdy, 1'b1);
        in_if.in_valid = 1'b0;
        tb_xor = tb_xor ^ w;
    endtask

    task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
        send(tb_xor, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n         = 1'b0;
        start          = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.in_data  = '0;
        tb_xor         = '0;
        repeat (3) tick();
        check("reset_cpu_enable", cpu_enable, 1'b0);
        check("reset_in_ready",   in_if.in_ready, 1'b0);
        arst_n = 1'b1;
        repeat (2) tick();

        // T1: two instruction words, continuous valid
        start_load();
        send(32'h0000_0002, 0);
        send(32'h0050_0093, 0);
        send(32'h00A0_0113, 0);
        end_frame();
        @(negedge clk);
        check("t1_enable_lag", cpu_enable, 1'b0);
        @(negedge clk);
        check("t1_enable_rise", cpu_enable, 1'b1);
        check("t1_done", done, 1'b1);
        tick();
        check("t1_nwrites", cap_ia.size(), 2);
        if (cap_ia.size() == 2) begin
            check("t1_addr0", cap_ia[0], 64'h0);
            check("t1_data0", cap_id[0], 32'h0050_0093);
            check("t1_addr1", cap_ia[1], 64'h4);
            check("t1_data1", cap_id[1], 32'h00A0_0113);
        end

        // T2: restart from RUN, one data dword
        start_load();
        @(negedge clk);
        check("t2_enable_fall", cpu_enable, 1'b0);
        check("t2_busy", busy, 1'b1);
        tick();
        send(32'h0001_0000, 0);
        send(32'hDEAD_BEEF, 0);
        send(32'h0123_4567, 0);
        end_frame();
        repeat (2) tick();
        check("t2_done", done, 1'b1);
        check("t2_no_imem", cap_ia.size(), 0);
        check("t2_ndmem", cap_da.size(), 1);
        if (cap_da.size() == 1) begin
            check("t2_addr", cap_da[0], 64'h0);
            check("t2_data", cap_dd[0], 64'h0123_4567_DEAD_BEEF);
        end

        // T3: oversize headers are rejected
        start_load();
        send(32'h0000_0201, 0);
        tick();
        check("t3_error", error, 1'b1);
        check("t3_ready", in_if.in_ready, 1'b0);
        check("t3_enable", cpu_enable, 1'b0);
        check("t3_nwrites", cap_ia.size() + cap_da.size(), 0);
        start_load();
        send(32'h0401_0000, 0);
        tick();
        check("t3b_error", error, 1'b1);

        // T4: n_instr at the 512-word limit
        start_load();
        send(32'h0000_0200, 0);
        for (int i = 0; i < 512; i++) send(32'h1000 + 32'(i), 0);
        end_frame();
        repeat (2) tick();
        check("t4_done", done, 1'b1);
        check("t4_nwrites", cap_ia.size(), 512);
        if (cap_ia.size() == 512) begin
            check("t4_last_addr", cap_ia[511], 64'h7FC);
            check("t4_last_data", cap_id[511], 32'h11FF);
        end

        // T5: n_data at the 1024-dword limit
        start_load();
        send(32'h0400_0000, 0);
        tick();
        check("t5_hdr_ok", {busy, error}, 2'b10);
        for (int i = 0; i < 2048; i++) send(32'(i), 0);
        end_frame();
        repeat (2) tick();
        check("t5_done", done, 1'b1);
        check("t5_nwrites", cap_da.size(), 1024);
        if (cap_da.size() == 1024) begin
            check("t5_last_addr", cap_da[1023], 64'h1FF8);
            check("t5_last_data", cap_dd[1023], 64'h0000_07FF_0000_07FE);
        end

        // T6: random valid gaps during a 4-word instruction load
        start_load();
        send(32'h0000_0004, 1);
        send(32'h0000_0011, 1);
        send(32'h0000_0022, 1);
        send(32'h0000_0033, 1);
        send(32'h0000_0044, 1);
        end_frame();
        repeat (2) tick();
        check("t6_done", done, 1'b1);
        check("t6_nwrites", cap_ia.size(), 4);
        for (int i = 0; i < cap_ia.size() && i < 4; i++) check("t6_addr", cap_ia[i], 64'(4 * i));

        // T7: mixed frame with stalls and an ignored start mid-load
        start_load();
        send(32'h0001_0002, 1);
        send(32'hAAAA_0001, 1);
        pulse_start();
        send(32'hAAAA_0002, 1);
        send(32'h5555_0000, 1);
        send(32'h6666_0000, 1);
        end_frame();
        repeat (2) tick();
        check("t7_done", done, 1'b1);
        check("t7_ndmem", cap_da.size(), 1);
        if (cap_da.size() == 1) check("t7_data", cap_dd[0], 64'h6666_0000_5555_0000);

`ifdef LOADER_CHECKSUM_EN
        // T8: explicit checksum good and bad
        start_load();
        send(32'h0000_0001, 0);
        send(32'h0000_0013, 0);
        send(32'h0000_0012, 0);
        repeat (2) tick();
        check("t8_good_done", done, 1'b1);
        check("t8_good_enable", cpu_enable, 1'b1);
        start_load();
        send(32'h0000_0001, 0);
        send(32'h0000_0013, 0);
        send(32'h0000_0000, 0);
        repeat (2) tick();
        check("t8_bad_error", error, 1'b1);
        check("t8_bad_enable", cpu_enable, 1'b0);
`endif

        // T9: reset mid-INSTR, start at release ignored, clean reload
        start_load();
        send(32'h0000_0004, 0);
        send(32'h0000_000A, 0);
        send(32'h0000_000B, 0);
        arst_n = 1'b0;
        repeat (3) tick();
        check("t9_rst_outputs", {cpu_enable, busy, done, error, wen_ext, wen_ext_2}, 6'd0);
        arst_n = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("t9_start_at_release", busy, 1'b0);
        tick();
        start_load();
        send(32'h0000_0001, 0);
        send(32'h0000_0077, 0);
        end_frame();
        repeat (2) tick();
        check("t9_done", done, 1'b1);
        check("t9_nwrites", cap_ia.size(), 1);
        if (cap_ia.size() == 1) begin
            check("t9_addr", cap_ia[0], 64'h0);
            check("t9_data", cap_id[0], 32'h77);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
# cpu_program_loader

Boot-time loader that sits directly upstream of the `cpu` top. It consumes a 32-bit valid/ready word stream carrying a framed program image and writes instruction memory through the `*_ext` ports and data memory through the `*_ext_2` ports. After the final write it raises the CPU `enable`, and holds it until the next load.

## Interface
- `IMEM_WORDS`, 512, instruction-memory capacity in 32-bit words.
- `DMEM_WORDS`, 1024, data-memory capacity in 64-bit words.
- `clk`  input  1  main clock; single clock domain.
- `arst_n`  input  1  asynchronous active-low reset.
- `start`  input  1  single-cycle pulse that begins a load; ignored while a load is in progress.
- `in_valid` / `in_ready`  input / output  1 / 1  stream handshake; a beat transfers when both are high on a rising edge.
- `in_data`  input  32  stream word.
- `addr_ext`  output  64  instruction-memory byte address.
- `wen_ext`  output  1  instruction-memory write strobe.
- `ren_ext`  output  1  tied 0.
- `wdata_ext`  output  32  instruction-memory write word.
- `addr_ext_2`  output  64  data-memory byte address.
- `wen_ext_2`  output  1  data-memory write strobe.
- `ren_ext_2`  output  1  tied 0.
- `wdata_ext_2`  output  64  data-memory write word.
- `cpu_enable`  output  1  drives the CPU `enable`.
- `busy`, `done`, `error`  output  1 each  status flags.

## Operation
- Frame format:
  - Header word: `{n_data[15:0], n_instr[15:0]}`.
  - Then `n_instr` instruction words.
  - Then `2*n_data` data beats, low half first.
  - Then a checksum word, only when the checksum feature is compiled in.
- Addressing:
  - Instruction word k is written to byte address 4k.
  - Data dword k is written to byte address 8k.
  - Both counts start at 0 each load.
- States and transitions:
  - IDLE, `start` → HEADER.
  - HEADER, header beat accepted:
    - `n_instr > IMEM_WORDS` or `n_data > DMEM_WORDS` → ERROR.
    - Else → INSTR if `n_instr != 0`, else DATA_LO if `n_data != 0`, else CHECK/RUN.
  - INSTR, after the `n_instr`-th accepted beat → DATA_LO, or CHECK/RUN if `n_data == 0`.
  - DATA_LO, lower half accepted and latched → DATA_HI.
  - DATA_HI, upper half accepted and the dword written → DATA_LO, or CHECK/RUN after the `n_data`-th dword.
  - CHECK, checksum compared → RUN on match, ERROR on mismatch.
  - RUN and ERROR, `start` → HEADER.
- `in_ready` is 1 in HEADER, INSTR, DATA_LO, DATA_HI and CHECK, and 0 elsewhere.
- `busy` is 1 in HEADER through CHECK.
- `done` is 1 in RUN; `error` is 1 in ERROR.
- `cpu_enable` is 0 in every state except RUN.

## Timing
- Reset: every output is 0, state is IDLE, and all counters are cleared. Reset mid-load abandons the load; the memory contents are then undefined.
- Write latency: a write strobe pulses for exactly one cycle, the cycle after the accepting edge. Address and data are registered together with the strobe.
- One instruction write per accepted INSTR beat. One data write per accepted DATA_HI beat; DATA_LO beats produce no write.
- `cpu_enable` rises 2 cycles after the final accepted beat, i.e. one cycle after the last write strobe. With the checksum feature, the final beat is the checksum word, which produces no write.
- Restart from RUN: `cpu_enable` falls in the cycle after `start`.
- `start` during HEADER…CHECK has no effect. `start` coincident with reset release is ignored.
- Stalls: `in_valid` low stalls the current state indefinitely; no partial state is lost.
- Counters are 16 bit. Address = count shifted left by 2 (instruction) or 3 (data), zero-extended to 64 bit.

## Configuration
- `LOADER_CHECKSUM_EN`, defined:
  - CHECK state exists; the running XOR covers the header and all payload beats.
  - The trailing checksum word must equal the running XOR; a mismatch → ERROR, and `cpu_enable` stays 0.
- `LOADER_CHECKSUM_EN`, undefined:
  - No CHECK state; the frame ends with the last payload beat.

## Test plan
- Header `0x0000_0002`, instruction words `0x00500093`, `0x00A00113`, continuous valid → writes to addresses 0x0 and 0x4 one cycle after each accept. `cpu_enable` rises 2 cycles after the last accept; `done` = 1.
- Header `0x0001_0000`, beats `0xDEADBEEF`, `0x01234567` → exactly one `wen_ext_2` pulse: address 0x0, data `0x01234567DEADBEEF`. No `wen_ext` pulse.
- Header `0x0000_0201` (`n_instr` = 513 > 512) → ERROR after the header beat; no writes; `cpu_enable` = 0; `in_ready` = 0.
- `in_valid` toggled randomly during a 4-word instruction load → addresses are still 0x0, 0x4, 0x8, 0xC in order, with one strobe each.
- With `LOADER_CHECKSUM_EN`, header `0x0000_0001`, word `0x00000013`, checksum `0x00000012` → RUN. Checksum `0x00000000` → ERROR.
- Assert `arst_n` low mid-INSTR, then release and pulse `start` → all outputs 0 during reset; the new load restarts at address 0x0.
